// File: rtl/opregister_arbiter_pkg.sv
// Shared definitions for the opregister arbiter: FSM state encoding,
// requester index constants, command encoding and a one-hot helper.
package opregister_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  // Requester index -> one-hot two-bit vector.
  function automatic logic [1:0] onehot2(input logic idx);
    return (idx == REQ1) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/opregister_arbiter_rr.sv
// Combinational two-way round-robin picker.
// Ports:
//   valid     - per-requester request valid
//   pointer   - requester favoured when both are valid
//   grant     - one-hot grant (all zero when nothing is valid)
//   grant_idx - index of the granted requester (REQ0 when none)
module rr_arbiter2
  import opregister_arbiter_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       pointer,
  output logic [1:0] grant,
  output logic       grant_idx
);

  always_comb begin
    grant_idx = REQ0;
    grant     = '0;
    case (valid)
      2'b01:   grant_idx = REQ0;
      2'b10:   grant_idx = REQ1;
      2'b11:   grant_idx = pointer;
      default: grant_idx = REQ0;
    endcase
    if (|valid) grant = onehot2(grant_idx);
  end

endmodule

// File: rtl/opregister_arbiter.sv
// Round-robin arbiter sharing one operation register between two requesters.
// Sequences the register's we/oe/opsel/data pins and returns the register
// value to the granted requester as a one-cycle response pulse.
// Ports:
//   i_w_clk, i_w_reset              - clock, async active-low reset
//   i_w_req_valid / o_w_req_ready   - per-requester request handshake
//   i_w_req_write                   - per-requester command (1 = write-with-op)
//   i_w_req_opsel0/1, i_w_req_data0/1 - per-requester payload
//   o_w_rsp_valid, o_w_rsp_data     - response pulse and register value
//   o_w_we, o_w_oe, o_w_opsel, o_w_data, i_w_reg_out - opregister interface
//   o_w_busy                        - high whenever not idle
module opregister_arbiter
  import opregister_arbiter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int OPSEL_W = 2
) (
  input  logic               i_w_clk,
  input  logic               i_w_reset,
  input  logic [1:0]         i_w_req_valid,
  output logic [1:0]         o_w_req_ready,
  input  logic [1:0]         i_w_req_write,
  input  logic [OPSEL_W-1:0] i_w_req_opsel0,
  input  logic [OPSEL_W-1:0] i_w_req_opsel1,
  input  logic [WIDTH-1:0]   i_w_req_data0,
  input  logic [WIDTH-1:0]   i_w_req_data1,
  output logic [1:0]         o_w_rsp_valid,
  output logic [WIDTH-1:0]   o_w_rsp_data,
  output logic               o_w_we,
  output logic               o_w_oe,
  output logic [OPSEL_W-1:0] o_w_opsel,
  output logic [WIDTH-1:0]   o_w_data,
  input  logic [WIDTH-1:0]   i_w_reg_out,
  output logic               o_w_busy
);

  state_t               state;
  logic                 pointer;
  logic                 owner;
  logic                 write_q;
  logic [OPSEL_W-1:0]   opsel_q;
  logic [WIDTH-1:0]     data_q;
  logic [WIDTH-1:0]     result;

  logic [1:0]           grant;
  logic                 grant_idx;

  rr_arbiter2 u_rr (
    .valid     (i_w_req_valid),
    .pointer   (pointer),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_ff @(posedge i_w_clk or negedge i_w_reset) begin
    if (!i_w_reset) begin
      state   <= S_IDLE;
      pointer <= REQ0;
      owner   <= REQ0;
      write_q <= CMD_READ;
      opsel_q <= '0;
      data_q  <= '0;
      result  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|i_w_req_valid) begin
            owner   <= grant_idx;
            write_q <= i_w_req_write[grant_idx];
            opsel_q <= (grant_idx == REQ1) ? i_w_req_opsel1 : i_w_req_opsel0;
            data_q  <= (grant_idx == REQ1) ? i_w_req_data1 : i_w_req_data0;
            state   <= (i_w_req_write[grant_idx] == CMD_WRITE) ? S_WRITE : S_READ;
          end
        end
        S_WRITE: state <= S_READ;
        S_READ: begin
          result <= i_w_reg_out;
          state  <= S_RESP;
        end
        S_RESP: begin
          pointer <= ~owner;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Ready is the only output with a combinational path from inputs, so it is
  // gated by reset directly to keep every output at 0 while reset is held.
  always_comb begin
    o_w_req_ready = '0;
    o_w_rsp_valid = '0;
    o_w_we        = 1'b0;
    o_w_oe        = 1'b0;
    o_w_opsel     = '0;
    o_w_data      = '0;
    o_w_busy      = (state != S_IDLE);
    o_w_rsp_data  = result;
    case (state)
      S_IDLE:  if (i_w_reset) o_w_req_ready = grant;
      S_WRITE: begin
        o_w_we    = 1'b1;
        o_w_opsel = opsel_q;
        o_w_data  = data_q;
      end
      S_READ:  o_w_oe = 1'b1;
      S_RESP:  o_w_rsp_valid = onehot2(owner);
      default: ;
    endcase
  end

endmodule

// File: tb/tb_opregister_arbiter.sv
module tb_opregister_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req_v;
  logic [1:0] ready;
  logic [1:0] req_w;
  logic [1:0] req_op [2];
  logic [3:0] req_d  [2];
  logic [1:0] rsp_valid;
  logic [3:0] rsp_data;
  logic       we, oe, busy;
  logic [1:0] opsel;
  logic [3:0] wdata;
  logic [3:0] reg_out;

  always #5 clk = ~clk;

  opregister_arbiter #(.WIDTH(4), .OPSEL_W(2)) dut (
    .i_w_clk        (clk),
    .i_w_reset      (rst_n),
    .i_w_req_valid  (req_v),
    .o_w_req_ready  (ready),
    .i_w_req_write  (req_w),
    .i_w_req_opsel0 (req_op[0]),
    .i_w_req_opsel1 (req_op[1]),
    .i_w_req_data0  (req_d[0]),
    .i_w_req_data1  (req_d[1]),
    .o_w_rsp_valid  (rsp_valid),
    .o_w_rsp_data   (rsp_data),
    .o_w_we         (we),
    .o_w_oe         (oe),
    .o_w_opsel      (opsel),
    .o_w_data       (wdata),
    .i_w_reg_out    (reg_out),
    .o_w_busy       (busy)
  );

  // Operation performed by the register on a write.
  function automatic logic [3:0] op_f(input logic [1:0] s, input logic [3:0] r,
                                      input logic [3:0] d);
    case (s)
      2'd0:    return d;
      2'd1:    return r + d;
      2'd2:    return r ^ d;
      default: return r & d;
    endcase
  endfunction

  // Stand-in opregister driven by the DUT's control pins.
  logic [3:0] reg_q = 4'hA;
  always @(posedge clk) if (we) reg_q <= op_f(opsel, reg_q, wdata);
  assign reg_out = oe ? reg_q : 4'h0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic       owner;
    logic       write;
    logic [1:0] opsel;
    logic [3:0] data;
    logic [3:0] exp;
    int         hs;
  } txn_t;
  txn_t q[$];

  // Reference model state: register contents, last served owner and the
  // earliest cycle in which the next grant can happen.
  logic [3:0] model_val  = 4'hA;
  logic [3:0] model_prev = 4'hA;
  logic       last_owner = 1'b1;
  int         next_free  = 0;
  logic [1:0] pend_clr   = '0;

  task automatic next_cycle();
    @(negedge clk);
    for (int n = 0; n < 2; n++) if (pend_clr[n]) req_v[n] = 1'b0;
    pend_clr = '0;
  endtask

  task automatic sample();
    logic [1:0] exp_ready;
    logic       g;
    txn_t       t;
    #1;
    exp_ready = '0;
    g = 1'b0;
    if (cyc >= next_free && |req_v) begin
      g = (req_v == 2'b11) ? ~last_owner : req_v[1];
      exp_ready[g] = 1'b1;
    end
    check("ready", ready, exp_ready);
    if (|exp_ready) begin
      model_prev = model_val;
      if (req_w[g]) model_val = op_f(req_op[g], model_val, req_d[g]);
      t.owner = g; t.write = req_w[g]; t.opsel = req_op[g]; t.data = req_d[g];
      t.exp = model_val; t.hs = cyc;
      q.push_back(t);
      next_free = cyc + (req_w[g] ? 4 : 3);
      last_owner = g;
      pend_clr[g] = 1'b1;
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin next_cycle(); sample(); end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, ready, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_data"}, rsp_data, 0);
    check({tag, "_we"}, we, 0);
    check({tag, "_oe"}, oe, 0);
    check({tag, "_opsel"}, opsel, 0);
    check({tag, "_data"}, wdata, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  // Monitor: checks register pin sequencing and pops responses.
  initial begin
    txn_t f;
    bit   have;
    int   rsp_cyc;
    forever begin
      @(negedge clk);
      #2;
      have = (q.size() > 0);
      if (have) f = q[0];
      rsp_cyc = have ? f.hs + (f.write ? 3 : 2) : 0;
      check("we", we, have && f.write && cyc == f.hs + 1);
      check("oe", oe, have && cyc == f.hs + (f.write ? 2 : 1));
      check("busy", busy, have && cyc > f.hs);
      check("we_oe_excl", we & oe, 0);
      check("opsel_pin", opsel, (have && f.write && cyc == f.hs + 1) ? f.opsel : 2'd0);
      check("data_pin", wdata, (have && f.write && cyc == f.hs + 1) ? f.data : 4'd0);
      if (|rsp_valid || (have && cyc >= rsp_cyc)) begin
        if (!have) check("rsp_unexpected", rsp_valid, 0);
        else begin
          check("rsp_valid", rsp_valid, f.owner ? 2'b10 : 2'b01);
          check("rsp_data", rsp_data, f.exp);
          check("rsp_cycle", cyc, rsp_cyc);
          void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    int grants;
    rst_n = 1'b0;
    req_v = 2'b11;
    req_w = 2'b00;
    for (int n = 0; n < 2; n++) begin req_op[n] = '0; req_d[n] = '0; end

    // Reset state with both valids asserted.
    repeat (2) @(negedge clk);
    #1 check_all_zero("reset");
    req_v = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    idle_cycles(5);

    // Requester 0 read alone (register holds A).
    next_cycle();
    req_v = 2'b01; req_w[0] = 1'b0;
    sample();
    idle_cycles(4);

    // Requester 1 write, opsel 1, data 3.
    next_cycle();
    req_v = 2'b10; req_w[1] = 1'b1; req_op[1] = 2'b01; req_d[1] = 4'h3;
    sample();
    idle_cycles(5);

    // Both continuously valid for four reads: alternate grants.
    req_w = 2'b00;
    grants = 0;
    for (int i = 0; i < 30 && grants < 4; i++) begin
      next_cycle();
      req_v = 2'b11;
      sample();
      if (|pend_clr) grants++;
    end
    check("four_grants", grants, 4);
    next_cycle(); req_v = 2'b00; sample();
    idle_cycles(4);

    // Requester 0 waits while requester 1 writes; original payload is served.
    next_cycle();
    req_v = 2'b10; req_w[1] = 1'b1; req_op[1] = 2'b10; req_d[1] = 4'h6;
    sample();
    next_cycle();
    req_v[0] = 1'b1; req_w[0] = 1'b1; req_op[0] = 2'b00; req_d[0] = 4'h9;
    sample();
    idle_cycles(6);

    // Reset asserted during WRITE drops the transaction.
    next_cycle();
    req_v = 2'b10; req_w[1] = 1'b1; req_op[1] = 2'b00; req_d[1] = 4'h5;
    sample();
    @(posedge clk);
    #1 check("we_before_reset", we, 1);
    #1 rst_n = 1'b0;
    req_v = 2'b11; pend_clr = '0;
    #1 check_all_zero("async_reset");
    q.delete();
    model_val = model_prev;
    last_owner = 1'b1;
    next_free = 0;
    next_cycle();
    rst_n = 1'b1;
    req_w = 2'b00;
    sample();
    check("post_reset_winner", last_owner, 0);
    idle_cycles(4);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      next_cycle();
      for (int n = 0; n < 2; n++) begin
        if (!req_v[n] && $urandom_range(0, 99) < 45) begin
          req_v[n]  = 1'b1;
          req_w[n]  = 1'($urandom_range(0, 1));
          req_op[n] = 2'($urandom_range(0, 3));
          req_d[n]  = 4'($urandom_range(0, 15));
        end else if (!req_v[n]) begin
          req_d[n] = 4'($urandom_range(0, 15));
        end
      end
      sample();
    end

    // Drain: stop issuing and let outstanding responses finish.
    for (int i = 0; i < 12; i++) begin
      next_cycle();
      req_v = 2'b00;
      pend_clr = '0;
      sample();
    end
    check("queue_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/opregister_arbiter.md
Name: opregister_arbiter

Overview:
- Shares one operation register between two requesters (index 0 and 1) using round-robin arbitration.
- Sequences the register's control interface (we, oe, opsel, data) and returns the register value to the granted requester.
- Each request uses a valid/ready handshake and completes with a one-cycle response pulse.
- Sits between two client blocks and a single opregister instance; it is the only driver of that register's control pins.

Parameters:
- WIDTH, 4, data width of the register and of request/response data.
- OPSEL_W, 2, width of the operation-select field.

Ports:
- i_w_clk  input  1  system clock, rising edge.
- i_w_reset  input  1  asynchronous, active-low reset.
- i_w_req_valid  input  2  per-requester request valid; bit n belongs to requester n.
- o_w_req_ready  output  2  per-requester request accepted; at most one bit high.
- i_w_req_write  input  2  per-requester command type: 1 = write-with-op, 0 = read.
- i_w_req_opsel0 / i_w_req_opsel1  input  OPSEL_W  operation select for requester 0 / 1.
- i_w_req_data0 / i_w_req_data1  input  WIDTH  write data for requester 0 / 1.
- o_w_rsp_valid  output  2  one-cycle response pulse to the owning requester.
- o_w_rsp_data  output  WIDTH  register value sampled for the current response.
- o_w_we  output  1  write enable to the opregister.
- o_w_oe  output  1  output enable to the opregister.
- o_w_opsel  output  OPSEL_W  operation select to the opregister.
- o_w_data  output  WIDTH  write data to the opregister.
- i_w_reg_out  input  WIDTH  opregister output; valid while o_w_oe = 1.
- o_w_busy  output  1  high in every state except IDLE.

Behaviour:
- FSM states: IDLE, WRITE, READ, RESP. All control outputs are Moore-decoded from the state and latched command registers.
- Reset (async, i_w_reset = 0):
  - State goes to IDLE; round-robin pointer goes to 0.
  - Latched command, owner and result registers clear to 0.
  - All outputs are 0 immediately, not waiting for a clock edge.
  - A transaction in flight is dropped silently; no response is issued for it.
- IDLE arbitration:
  - Only one requester valid: that requester is granted.
  - Both valid: the requester named by the pointer is granted.
  - The granted requester's o_w_req_ready is asserted combinationally in the same cycle.
  - On the handshake edge: latch owner, write flag, opsel and data. Go to WRITE if write = 1, else READ.
  - No valid: stay in IDLE, ready = 2'b00.
- WRITE, one cycle:
  - o_w_we = 1, o_w_opsel and o_w_data come from the latch; the register updates at the end of the cycle.
  - Next state is READ.
- READ, one cycle:
  - o_w_oe = 1.
  - At the end of the cycle, i_w_reg_out is captured into the result register. Next state is RESP.
- RESP, one cycle:
  - o_w_rsp_valid[owner] = 1 and o_w_rsp_data = result.
  - Pointer is set to ~owner. Next state is IDLE.
- Latency from handshake edge to response pulse:
  - Read: 2 cycles (READ, RESP).
  - Write: 3 cycles (WRITE, READ, RESP).
  - A new grant is possible in the cycle after RESP.
- Output values outside their active state:
  - o_w_rsp_data holds the last result; it is meaningful only while o_w_rsp_valid is high.
  - o_w_we and o_w_oe are never high together.
  - o_w_opsel and o_w_data are 0 outside WRITE.
- Request rules:
  - A requester holds valid and its payload stable until ready.
  - Payload changes after the handshake do not affect the transaction in flight.
  - Valid from either requester during WRITE/READ/RESP is ignored (ready = 0) and stays pending.
- Fairness:
  - With both requesters continuously valid, grants alternate 0, 1, 0, 1, ...
  - A single active requester is granted back-to-back with no idle penalty.

Decomposition:
- Shared package/header (opregister_arbiter_pkg):
  - state encoding: S_IDLE = 2'd0, S_WRITE = 2'd1, S_READ = 2'd2, S_RESP = 2'd3;
  - requester index constants REQ0 = 1'b0, REQ1 = 1'b1;
  - command encoding CMD_READ = 1'b0, CMD_WRITE = 1'b1.
- One sub-module, rr_arbiter2:
  - combinational two-way round-robin picker;
  - inputs: valid[1:0], pointer;
  - outputs: grant[1:0] one-hot and grant_idx.
- The pointer register lives in the parent.

Test Plan:
- Reset, then idle: all outputs 0, busy = 0; after release with no valid, ready stays 2'b00 for 5 cycles.
- Requester 0 read alone, with model register = 4'hA: ready[0] in cycle 0; oe = 1 in cycle 1; rsp_valid = 2'b01 with rsp_data = 4'hA in cycle 2; busy falls in cycle 3.
- Requester 1 write, data 4'h3, opsel 2'b01: we = 1 with opsel = 2'b01 and data = 4'h3 in cycle 1; oe in cycle 2; rsp_valid = 2'b10 with rsp_data equal to the post-op register value in cycle 3.
- Both requesters valid continuously for 4 reads after reset: grant order is 0, 1, 0, 1; ready is never 2'b11; we and oe are never high together.
- Reset asserted during WRITE: all outputs go to 0 asynchronously, no rsp_valid pulse; after release, pointer = 0, so requester 0 wins a simultaneous request.
- Requester 0 holds valid during requester 1's transaction: ready[0] = 0 until the cycle after RESP, then is granted with its original payload.
